sel_sequencer: RTL and testbench
================================

Name: sel_sequencer

Overview:
- Generates the 3-bit select code that drives the 3-to-8 one-hot LED decoder stage directly downstream.
- Steps the code automatically at a programmable rate, or one position per debounced push-button press.
- Supports up/down counting with either wrap-around or ping-pong (bounce) sequencing.
- Emits a pulse on every code change and on every wrap or reversal, so downstream logic can count cycles.

Parameters:
- PRESCALE_W, 8, width of the period input and the internal prescaler counter.
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles step_btn must hold a new level before that level is accepted (≥1).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  1 = RUN (auto-advance), 0 = IDLE (manual step only).
- step_btn  in  1  raw, asynchronous push-button input.
- dir  in  1  0 = count up, 1 = count down.
- pingpong  in  1  0 = wrap mode, 1 = bounce mode.
- period  in  PRESCALE_W  auto-advance interval minus 1 (advance every period+1 cycles).
- sel  out  3  select code to the decoder.
- sel_valid  out  1  high once the block is out of reset.
- tick  out  1  one-cycle pulse in the cycle sel holds a new value.
- wrap  out  1  one-cycle pulse with tick when the move wrapped (7↔0) or reversed direction.

Behaviour:
- Reset (async assert; clocked release): sel=0, sel_valid=0, tick=0, wrap=0, prescaler=0, state IDLE, sync/debounce flops=0, pp_dir=0, debounced level=0.
- sel_valid goes 1 at the first rising edge after rst deasserts and stays 1.
- All outputs are registered.
- States and transitions:
  - IDLE→RUN when en=1 is sampled; prescaler cleared.
  - RUN→IDLE when en=0 is sampled; prescaler cleared, sel held.
  - pp_dir is loaded from dir on reset release and on every IDLE→RUN entry.
- RUN:
  - Prescaler increments every cycle.
  - When prescaler==period, the next edge advances sel, sets prescaler=0 and pulses tick.
  - period=0 advances every cycle.
  - A period change takes effect at the next compare; prescaler>period after a change is treated as a match (advance next edge).
- IDLE: each accepted step event advances sel by one position on the edge after the event.
- Step events are ignored in RUN.
- Debounce:
  - step_btn passes a 2-flop synchroniser.
  - A counter increments each edge the synchronised value differs from the debounced level and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A 0→1 flip generates a one-cycle step event.
  - With DEBOUNCE_CYCLES=4, sel changes on the 7th rising edge after step_btn rises and stays high.
- Wrap mode (pingpong=0):
  - Up: 7→0. Down: 0→7.
  - wrap pulses on those moves.
  - dir is sampled live at each advance.
- Ping-pong mode (pingpong=1), direction from pp_dir:
  - Up at 7: flip pp_dir, go to 6.
  - Down at 0: flip pp_dir, go to 1.
  - wrap pulses on the reversal move.
  - dir is ignored except at the pp_dir load points.
- Mode switch mid-run: pingpong is sampled at each advance. Switching to pingpong loads pp_dir from dir on the first advance in that mode.
- Simultaneous events: an en falling edge in the same cycle as a prescaler match is resolved in favour of the advance, then IDLE. A step event coinciding with IDLE→RUN is discarded.
- Reset mid-operation: immediate return to the reset values, including a partially debounced press.
- tick and wrap are never high for more than one consecutive cycle unless period=0.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN};
  - SEL_W=3, SEL_MAX=3'd7 constants;
  - dir encoding constants DIR_UP=0, DIR_DOWN=1.
- Sub-module btn_debounce (synchroniser + stability counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), reusable for other push-button inputs.
- Sequencer FSM, prescaler and next-code logic stay in sel_sequencer.

Test Plan:
- Reset, then en=1, dir=0, pingpong=0, period=2 → sel 0,1,2,…,7,0 changing every 3 cycles; tick on each change; wrap with the 7→0 move only.
- en=1, dir=1, pingpong=1, period=0 starting at sel=2 → sel 1,0,1,2,…,7,6 every cycle; wrap on the 0→1 and 7→6 moves.
- en=0, step_btn held high 10 cycles, DEBOUNCE_CYCLES=4 → single advance 0→1 on the 7th edge. A 3-cycle glitch on step_btn → no advance.
- en=0, press step while sel=7, dir=0, pingpong=0 → sel=0 with tick=1, wrap=1. Press again with en=1 → ignored.
- Assert rst mid-run at sel=5 with a press half-debounced → sel=0, sel_valid=0, tick=0 immediately. After release, no stale step event fires.
- en falls in the same cycle as a prescaler match (period=3) → one final advance, then sel holds indefinitely with tick=0.

Source files
------------

// File: rtl/sel_sequencer_pkg.sv
// ============================================================================
// Module  : sel_sequencer_pkg
// Purpose : Shared state, width and direction definitions for the select
//           sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sel_sequencer_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int unsigned      SEL_W   = 3;
   localparam logic [SEL_W-1:0] SEL_MAX = 3'd7;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module  : btn_debounce
// Purpose : Synchronises a raw push-button input, filters bounce and emits a
//           one-cycle pulse on each accepted press.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic press
);

   localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = btn_in;
      sync2_d = sync1_q;
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      // The counter runs only while the synchronised input disagrees with
      // the accepted level; any agreement restarts the stability window.
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press = press_q;

endmodule

`default_nettype wire

// File: rtl/sel_sequencer.sv
// ============================================================================
// Module  : sel_sequencer
// Purpose : 3-bit select code generator for a one-hot LED decoder, stepping
//           automatically or by push-button, in wrap or ping-pong order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sel_sequencer #(
   parameter int PRESCALE_W      = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  step_btn,
   input  logic                  dir,
   input  logic                  pingpong,
   input  logic [PRESCALE_W-1:0] period,
   output logic [2:0]            sel,
   output logic                  sel_valid,
   output logic                  tick,
   output logic                  wrap
);

   import sel_sequencer_pkg::*;

   state_e                state_q, state_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic                  tick_q, tick_d;
   logic                  wrap_q, wrap_d;
   logic                  valid_q, valid_d;
   logic                  pp_dir_q, pp_dir_d;
   logic                  pp_armed_q, pp_armed_d;
   logic                  step;
   logic                  advance;
   logic                  mv_dir;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk   (clk),
      .rst   (rst),
      .btn_in(step_btn),
      .press (step)
   );

   // pp_armed marks pp_dir as current for ping-pong; a wrap-mode advance
   // clears it so the next ping-pong advance reloads from dir.
   assign mv_dir = pp_armed_q ? pp_dir_q : dir;

   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      sel_d      = sel_q;
      tick_d     = 1'b0;
      wrap_d     = 1'b0;
      valid_d    = 1'b1;
      pp_dir_d   = pp_dir_q;
      pp_armed_d = pp_armed_q;
      advance    = 1'b0;

      if (!valid_q) begin
         pp_dir_d   = dir;
         pp_armed_d = 1'b1;
      end

      if (state_q == IDLE) begin
         if (en) begin
            state_d    = RUN;
            presc_d    = '0;
            pp_dir_d   = dir;
            pp_armed_d = 1'b1;
         end else if (step) begin
            advance = 1'b1;
         end
      end else begin
         // >= also catches a prescaler left above a freshly lowered period.
         if (presc_q >= period) begin
            advance = 1'b1;
            presc_d = '0;
         end else begin
            presc_d = presc_q + 1'b1;
         end
         if (!en) begin
            state_d = IDLE;
            presc_d = '0;
         end
      end

      if (advance) begin
         tick_d = 1'b1;
         if (pingpong) begin
            pp_armed_d = 1'b1;
            if (mv_dir == DIR_UP && sel_q == SEL_MAX) begin
               sel_d    = SEL_MAX - 1'b1;
               pp_dir_d = DIR_DOWN;
               wrap_d   = 1'b1;
            end else if (mv_dir == DIR_DOWN && sel_q == '0) begin
               sel_d    = SEL_W'(1);
               pp_dir_d = DIR_UP;
               wrap_d   = 1'b1;
            end else begin
               sel_d    = (mv_dir == DIR_UP) ? sel_q + 1'b1 : sel_q - 1'b1;
               pp_dir_d = mv_dir;
            end
         end else begin
            pp_armed_d = 1'b0;
            sel_d      = (dir == DIR_UP) ? sel_q + 1'b1 : sel_q - 1'b1;
            wrap_d     = (dir == DIR_UP) ? (sel_q == SEL_MAX) : (sel_q == '0);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         presc_q    <= '0;
         sel_q      <= '0;
         tick_q     <= 1'b0;
         wrap_q     <= 1'b0;
         valid_q    <= 1'b0;
         pp_dir_q   <= 1'b0;
         pp_armed_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         sel_q      <= sel_d;
         tick_q     <= tick_d;
         wrap_q     <= wrap_d;
         valid_q    <= valid_d;
         pp_dir_q   <= pp_dir_d;
         pp_armed_q <= pp_armed_d;
      end
   end

   assign sel       = sel_q;
   assign sel_valid = valid_q;
   assign tick      = tick_q;
   assign wrap      = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_sel_sequencer.sv
// ============================================================================
// Module  : tb_sel_sequencer
// Purpose : Self-checking bench for sel_sequencer against a cycle model of
//           the select sequence, button filter and run/idle control.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sel_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       step_btn = 1'b0;
   logic       dir = 1'b0;
   logic       pingpong = 1'b0;
   logic [7:0] period = 8'd0;
   logic [2:0] sel;
   logic       sel_valid;
   logic       tick;
   logic       wrap;

   int    n_tests = 0;
   int    n_fail  = 0;
   string phase   = "init";

   // Reference model state
   int m_sel, m_run, m_cnt, m_ppdir, m_ppok, m_first;
   int m_tick, m_wrap, m_valid, m_lvl, m_press;
   int hist [0:7];

   sel_sequencer #(
      .PRESCALE_W     (8),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .step_btn (step_btn),
      .dir      (dir),
      .pingpong (pingpong),
      .period   (period),
      .sel      (sel),
      .sel_valid(sel_valid),
      .tick     (tick),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input int exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      chk({phase, ".sel"},       {29'd0, sel},       m_sel);
      chk({phase, ".sel_valid"}, {31'd0, sel_valid}, m_valid);
      chk({phase, ".tick"},      {31'd0, tick},      m_tick);
      chk({phase, ".wrap"},      {31'd0, wrap},      m_wrap);
   endtask

   task automatic model_reset();
      m_sel = 0; m_run = 0; m_cnt = 0; m_ppdir = 0; m_ppok = 0; m_first = 1;
      m_tick = 0; m_wrap = 0; m_valid = 0; m_lvl = 0; m_press = 0;
      for (int i = 0; i < 8; i++) hist[i] = 0;
   endtask

   // One rising edge of the specified behaviour, from the inputs as sampled.
   task automatic model_edge();
      int ev, adv, d, nx, stable;
      ev = m_press;
      m_press = 0;
      adv = 0;
      // Button: accepted level flips once the last four synchronised samples
      // (two-edge pipeline delay) all disagree with it.
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(step_btn);
      stable = 1;
      for (int i = 2; i <= 5; i++) if (hist[i] == m_lvl) stable = 0;
      if (stable == 1) begin
         m_lvl = 1 - m_lvl;
         m_press = m_lvl;
      end

      m_tick = 0;
      m_wrap = 0;
      if (m_first == 1) begin
         m_ppdir = int'(dir);
         m_ppok  = 1;
         m_first = 0;
      end
      if (m_run == 0) begin
         if (en) begin
            m_run = 1; m_cnt = 0; m_ppdir = int'(dir); m_ppok = 1;
         end else if (ev == 1) begin
            adv = 1;
         end
      end else begin
         if (m_cnt >= int'(period)) begin
            adv = 1; m_cnt = 0;
         end else begin
            m_cnt++;
         end
         if (!en) begin
            m_run = 0; m_cnt = 0;
         end
      end

      if (adv == 1) begin
         m_tick = 1;
         if (pingpong) begin
            d  = (m_ppok == 1) ? m_ppdir : int'(dir);
            nx = m_sel + ((d == 1) ? -1 : 1);
            if (nx < 0 || nx > 7) begin
               d = 1 - d;
               nx = m_sel + ((d == 1) ? -1 : 1);
               m_wrap = 1;
            end
            m_ppdir = d;
            m_ppok  = 1;
         end else begin
            nx = m_sel + (dir ? -1 : 1);
            if (nx < 0 || nx > 7) begin
               m_wrap = 1;
               nx = (nx + 8) % 8;
            end
            m_ppok = 0;
         end
         m_sel = nx;
      end
      m_valid = 1;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;
   endtask

   initial begin
      int ticks, wraps, first_tick, first_wrap, base, k;

      #2;
      phase = "reset";
      do_reset();
      run(2);

      // Wrap mode counting up, period 2: eight advances 0..7,0
      phase = "wrap_up";
      en = 1'b1; dir = 1'b0; pingpong = 1'b0; period = 8'd2;
      ticks = 0; wraps = 0;
      for (int i = 0; i < 25; i++) begin
         cyc();
         ticks += int'(tick);
         wraps += int'(wrap);
      end
      chk("wrap_up.ticks", ticks, 8);
      chk("wrap_up.wraps", wraps, 1);
      chk("wrap_up.final_sel", {29'd0, sel}, 0);
      k = 0;
      while (m_sel != 2 && k < 12) begin cyc(); k++; end
      chk("wrap_up.reach2", {29'd0, sel}, 2);
      en = 1'b0;
      cyc();

      // Ping-pong down from 2, period 0
      phase = "pingpong";
      en = 1'b1; dir = 1'b1; pingpong = 1'b1; period = 8'd0;
      cyc();
      ticks = 0; wraps = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         ticks += int'(tick);
         wraps += int'(wrap);
      end
      chk("pingpong.ticks", ticks, 10);
      chk("pingpong.wraps", wraps, 2);
      chk("pingpong.final_sel", {29'd0, sel}, 6);

      // Leaving RUN with period 0 still takes the matching advance (6->7)
      phase = "leave_run";
      en = 1'b0; dir = 1'b0; pingpong = 1'b0;
      cyc();
      run(3);

      // Button press at sel=7: 7->0 with wrap on the 7th edge
      phase = "press_wrap";
      step_btn = 1'b1; first_tick = 0; first_wrap = 0;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         if (tick && first_tick == 0) begin
            first_tick = i;
            first_wrap = int'(wrap);
         end
      end
      chk("press_wrap.edge", first_tick, 7);
      chk("press_wrap.wrap", first_wrap, 1);
      chk("press_wrap.sel", {29'd0, sel}, 0);
      step_btn = 1'b0;
      run(10);

      phase = "press_plain";
      step_btn = 1'b1; first_tick = 0; ticks = 0;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         ticks += int'(tick);
         if (tick && first_tick == 0) first_tick = i;
      end
      chk("press_plain.edge", first_tick, 7);
      chk("press_plain.count", ticks, 1);
      chk("press_plain.sel", {29'd0, sel}, 1);
      step_btn = 1'b0;
      run(10);

      phase = "glitch";
      base = m_sel;
      step_btn = 1'b1;
      run(3);
      step_btn = 1'b0;
      run(10);
      chk("glitch.sel", {29'd0, sel}, base);

      // Press while running is ignored
      phase = "press_in_run";
      en = 1'b1; period = 8'd255; step_btn = 1'b1; ticks = 0;
      for (int i = 0; i < 12; i++) begin cyc(); ticks += int'(tick); end
      step_btn = 1'b0;
      for (int i = 0; i < 8; i++) begin cyc(); ticks += int'(tick); end
      chk("press_in_run.ticks", ticks, 0);
      chk("press_in_run.sel", {29'd0, sel}, 1);
      en = 1'b0;
      cyc();

      // en falls exactly on a prescaler match
      phase = "en_fall_match";
      en = 1'b1; period = 8'd3;
      cyc();
      k = 0;
      while (!(m_run == 1 && m_cnt == 3) && k < 20) begin cyc(); k++; end
      en = 1'b0;
      cyc();
      chk("en_fall_match.last_tick", {31'd0, tick}, 1);
      base = m_sel;
      ticks = 0;
      for (int i = 0; i < 20; i++) begin cyc(); ticks += int'(tick); end
      chk("en_fall_match.hold_ticks", ticks, 0);
      chk("en_fall_match.hold_sel", {29'd0, sel}, base);

      // Reset mid-run at sel=5 with a half-debounced press
      phase = "mid_reset";
      en = 1'b1; period = 8'd1;
      k = 0;
      while (m_sel != 5 && k < 40) begin cyc(); k++; end
      chk("mid_reset.reach5", {29'd0, sel}, 5);
      step_btn = 1'b1;
      run(3);
      en = 1'b0;
      do_reset();
      step_btn = 1'b0;
      ticks = 0;
      for (int i = 0; i < 12; i++) begin cyc(); ticks += int'(tick); end
      chk("mid_reset.no_stale", ticks, 0);
      chk("mid_reset.sel", {29'd0, sel}, 0);

      // Randomized operation against the model
      phase = "random";
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0)  en = ~en;
         if ($urandom_range(0, 5) == 0)  dir = ~dir;
         if ($urandom_range(0, 9) == 0)  pingpong = ~pingpong;
         if ($urandom_range(0, 9) == 0)  period = 8'($urandom_range(0, 4));
         if ($urandom_range(0, 4) == 0)  step_btn = ~step_btn;
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
